// File: rtl/cirno9_lsarb_if.sv
// cirno9_lsarb_if: requester, SRAM and IOB signals of the load/store arbiter.
// The arbiter connects through the slave modport; the requester/fabric side uses master.
interface cirno9_lsarb_if;
    logic [2:0]  i_req_val;
    logic [2:0]  o_req_rdy;
    logic [95:0] i_req_adr;
    logic [95:0] i_req_wdat;
    logic [11:0] i_req_wen;
    logic [31:0] o_rdat;
    logic        o_err;
    logic        o_hs_ls4sram_val;
    logic [3:0]  o_sram_wen;
    logic [31:0] i_sram_rdat;
    logic        o_hs_ls4iob_val;
    logic        i_hs_iob4ls_rdy;
    logic [3:0]  o_iob_wen;
    logic [31:0] i_iob_rdat;
    logic [31:0] o_adr;
    logic [31:0] o_wdat;

    modport slave (
        input  i_req_val, i_req_adr, i_req_wdat, i_req_wen,
        input  i_sram_rdat, i_hs_iob4ls_rdy, i_iob_rdat,
        output o_req_rdy, o_rdat, o_err, o_hs_ls4sram_val, o_sram_wen,
        output o_hs_ls4iob_val, o_iob_wen, o_adr, o_wdat
    );

    modport master (
        output i_req_val, i_req_adr, i_req_wdat, i_req_wen,
        output i_sram_rdat, i_hs_iob4ls_rdy, i_iob_rdat,
        input  o_req_rdy, o_rdat, o_err, o_hs_ls4sram_val, o_sram_wen,
        input  o_hs_ls4iob_val, o_iob_wen, o_adr, o_wdat
    );
endinterface

// File: rtl/cirno9_lsarb.sv
// cirno9_lsarb: arbitrates the core memory port between IFU (0), EXU (1) and the
// AXI bridge (2), routing each access to SRAM (1-cycle read) or IOB (val/rdy with timeout).
// Build option CIRNO_LSARB_RR_EN: round-robin arbitration; undefined gives fixed
// priority 1 > 2 > 0.
module cirno9_lsarb #(
    parameter logic [31:0] SRAM_BASE = 32'h0000_0000,
    parameter logic [31:0] SRAM_MASK = 32'hFFFF_0000,
    parameter int unsigned IOB_TMO   = 16
) (
    input  logic          clk,
    input  logic          rst,
    cirno9_lsarb_if.slave bus
);
    localparam int unsigned NREQ  = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned BEW   = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IOB_TMO - 1);
    localparam logic [AW-1:0]    TMO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, SRAM, IOB, RESP} state_t;

    state_t                   r_state, w_state_nxt;
    logic [1:0]               r_gnt, w_gnt_nxt;
    logic [BEW-1:0]           r_wen, w_wen_nxt;
    logic [AW-1:0]            r_adr, w_adr_nxt;
    logic [AW-1:0]            r_wdat, w_wdat_nxt;
    logic                     r_hit, w_hit_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [AW-1:0]            r_rdat, w_rdat_nxt;
    logic                     r_err, w_err_nxt;
    logic [NREQ-1:0]          r_req_rdy;
    logic                     r_sram_val, r_iob_val;
    logic [BEW-1:0]           r_sram_wen, r_iob_wen;

    logic [NREQ-1:0][AW-1:0]  w_adr_arr, w_wdat_arr;
    logic [NREQ-1:0][BEW-1:0] w_wen_arr;
    logic [1:0]               w_win;
    logic                     w_any;

    assign w_adr_arr  = bus.i_req_adr;
    assign w_wdat_arr = bus.i_req_wdat;
    assign w_wen_arr  = bus.i_req_wen;
    assign w_any      = |bus.i_req_val;

`ifdef CIRNO_LSARB_RR_EN
    logic [1:0] r_ptr;

    // Round-robin pick: first valid requester at or after the pointer
    always_comb begin
        logic [2:0] w_sum;
        logic [1:0] w_idx;
        w_win = 2'd0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_sum = 3'(r_ptr) + 3'(k);
            w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : 2'(w_sum);
            if (bus.i_req_val[w_idx]) w_win = w_idx;
        end
    end

    // Search start moves past the winner at every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (r_state == IDLE && w_any) begin
            r_ptr <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
        end
    end
`else
    // Fixed priority pick: EXU, then AXI bridge, then fetch
    always_comb begin
        w_win = 2'd0;
        if (bus.i_req_val[2]) w_win = 2'd2;
        if (bus.i_req_val[1]) w_win = 2'd1;
    end
`endif

    // Next-state and datapath-register update
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_wen_nxt   = r_wen;
        w_adr_nxt   = r_adr;
        w_wdat_nxt  = r_wdat;
        w_hit_nxt   = r_hit;
        w_cnt_nxt   = r_cnt;
        w_rdat_nxt  = r_rdat;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                w_err_nxt = 1'b0;
                if (w_any) begin
                    w_gnt_nxt   = w_win;
                    w_adr_nxt   = w_adr_arr[w_win];
                    w_wdat_nxt  = w_wdat_arr[w_win];
                    w_wen_nxt   = w_wen_arr[w_win];
                    w_hit_nxt   = (w_adr_arr[w_win] & SRAM_MASK) == SRAM_BASE;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_hit_nxt ? SRAM : IOB;
                end
            end
            SRAM: w_state_nxt = RESP;
            IOB: begin
                // An accept in the final wait cycle still beats the timeout
                if (bus.i_hs_iob4ls_rdy) begin
                    w_rdat_nxt  = bus.i_iob_rdat;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_rdat_nxt  = TMO_DATA;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_err_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered strobes derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= 2'd0;
            r_wen      <= '0;
            r_adr      <= '0;
            r_wdat     <= '0;
            r_hit      <= 1'b0;
            r_cnt      <= '0;
            r_rdat     <= '0;
            r_err      <= 1'b0;
            r_req_rdy  <= '0;
            r_sram_val <= 1'b0;
            r_sram_wen <= '0;
            r_iob_val  <= 1'b0;
            r_iob_wen  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_wen      <= w_wen_nxt;
            r_adr      <= w_adr_nxt;
            r_wdat     <= w_wdat_nxt;
            r_hit      <= w_hit_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rdat     <= w_rdat_nxt;
            r_err      <= w_err_nxt;
            r_req_rdy  <= (w_state_nxt == RESP) ? (3'b001 << w_gnt_nxt) : 3'b000;
            r_sram_val <= (w_state_nxt == SRAM);
            r_sram_wen <= (w_state_nxt == SRAM) ? w_wen_nxt : '0;
            r_iob_val  <= (w_state_nxt == IOB);
            r_iob_wen  <= (w_state_nxt == IOB) ? w_wen_nxt : '0;
        end
    end

    // SRAM read data arrives the cycle after the strobe, so it passes straight through in RESP
    assign bus.o_rdat = (r_state == RESP && r_hit) ? bus.i_sram_rdat : r_rdat;

    assign bus.o_req_rdy        = r_req_rdy;
    assign bus.o_err            = r_err;
    assign bus.o_hs_ls4sram_val = r_sram_val;
    assign bus.o_sram_wen       = r_sram_wen;
    assign bus.o_hs_ls4iob_val  = r_iob_val;
    assign bus.o_iob_wen        = r_iob_wen;
    assign bus.o_adr            = r_adr;
    assign bus.o_wdat           = r_wdat;
endmodule

// File: tb/tb_cirno9_lsarb.sv
// tb_cirno9_lsarb: directed vector table plus hand sequences for contention and reset.
module tb_cirno9_lsarb;
    logic clk;
    logic rst;
    cirno9_lsarb_if bus ();

    cirno9_lsarb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       val;
        logic [2:0][31:0] adr;
        logic [2:0][31:0] wdat;
        logic [2:0][3:0]  wen;
        logic [31:0]      sram_rdat;
        int               rdy_after;   // IOB accept in this IOB cycle, 0 = never
        logic [31:0]      iob_rdat;
        logic [2:0]       exp_rdy;
        int               exp_lat;     // cycles from grant edge to rdy pulse
        int               exp_nsram;
        int               exp_niob;
        logic [31:0]      exp_rdat;
        logic             exp_err;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    int total;
    int bad;

    logic [2:0]  g_rdy;
    logic [31:0] g_rdat;
    logic        g_err;
    logic [3:0]  g_wen;
    int          g_lat;
    int          g_nsram;
    int          g_niob;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [2:0] oh);
        if (oh[2]) return 2;
        if (oh[1]) return 1;
        return 0;
    endfunction

    // Run one access to its rdy pulse, acting as the IOB target; keep=0 drops val on rdy
    task automatic run_one(input int rdy_after, input logic [31:0] iob_rdat, input bit keep);
        int  cyc;
        bit  done;
        cyc = 0;
        done = 1'b0;
        g_nsram = 0;
        g_niob = 0;
        g_wen = 4'h0;
        g_rdy = 3'b000;
        g_rdat = 32'h0;
        g_err = 1'b0;
        g_lat = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.i_hs_iob4ls_rdy = 1'b0;
            if (bus.o_hs_ls4sram_val) begin
                g_nsram++;
                g_wen = bus.o_sram_wen;
            end
            if (bus.o_hs_ls4iob_val) begin
                g_niob++;
                g_wen = bus.o_iob_wen;
                if (g_niob == rdy_after) begin
                    bus.i_hs_iob4ls_rdy = 1'b1;
                    bus.i_iob_rdat = iob_rdat;
                end
            end
            if (bus.o_req_rdy != 3'b000) begin
                g_rdy = bus.o_req_rdy;
                g_rdat = bus.o_rdat;
                g_err = bus.o_err;
                g_lat = cyc;
                done = 1'b1;
                if (!keep) bus.i_req_val = 3'b000;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL rdy_wait no rdy pulse within %0d cycles", cyc);
        end else begin
            @(posedge clk);
            #1;
            chk("rdy_one_shot", 32'(bus.o_req_rdy), 32'h0);
            chk("err_one_shot", 32'(bus.o_err), 32'h0);
        end
    endtask

    initial begin
        vec_t v;
        int g;
        logic [2:0] e5[4];

        total = 0;
        bad = 0;

        // T1 SRAM read by EXU
        vecs[0] = '{3'b010, {32'h1000_0000, 32'h0000_0010, 32'h0000_0040}, {32'h0, 32'h0, 32'h0},
                    {4'h0, 4'h0, 4'h0}, 32'h1234_5678, 0, 32'h0, 3'b010, 2, 1, 0, 32'h1234_5678, 1'b0};
        // T2 SRAM write by fetch
        vecs[1] = '{3'b001, {32'h0, 32'h0, 32'h0000_0020}, {32'h0, 32'h0, 32'hAABB_CCDD},
                    {4'h0, 4'h0, 4'b0011}, 32'h0BAD_F00D, 0, 32'h0, 3'b001, 2, 1, 0, 32'h0BAD_F00D, 1'b0};
        // T3 IOB read accepted in the third wait cycle
        vecs[2] = '{3'b100, {32'h1000_0000, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0},
                    {4'h0, 4'h0, 4'h0}, 32'h0, 3, 32'h0000_0055, 3'b100, 4, 0, 3, 32'h0000_0055, 1'b0};
        // T4 IOB timeout after 16 wait cycles
        vecs[3] = '{3'b100, {32'h2000_0000, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0},
                    {4'h0, 4'h0, 4'h0}, 32'h0, 0, 32'h0, 3'b100, 17, 0, 16, 32'hDEAD_BEEF, 1'b1};
        // Accept in the last allowed cycle wins over timeout
        vecs[4] = '{3'b100, {32'h3000_0004, 32'h0, 32'h0}, {32'h1122_3344, 32'h0, 32'h0},
                    {4'b1000, 4'h0, 4'h0}, 32'h0, 16, 32'hCAFE_0001, 3'b100, 17, 0, 16, 32'hCAFE_0001, 1'b0};
        // Top of SRAM window
        vecs[5] = '{3'b001, {32'h0, 32'h0, 32'h0000_FFFC}, {32'h0, 32'h0, 32'h0},
                    {4'h0, 4'h0, 4'hF}, 32'h7777_0000, 0, 32'h0, 3'b001, 2, 1, 0, 32'h7777_0000, 1'b0};
        // First address past SRAM window, accepted immediately
        vecs[6] = '{3'b001, {32'h0, 32'h0, 32'h0001_0000}, {32'h0, 32'h0, 32'h0},
                    {4'h0, 4'h0, 4'h0}, 32'h0, 1, 32'h0000_ABCD, 3'b001, 2, 0, 1, 32'h0000_ABCD, 1'b0};
        // Fetch vs AXI: AXI wins in both builds (RR search starts at 1 here)
        vecs[7] = '{3'b101, {32'h0000_0048, 32'h0, 32'h0000_0044}, {32'h2, 32'h0, 32'h1},
                    {4'h0, 4'h0, 4'h0}, 32'h2222_0000, 0, 32'h0, 3'b100, 2, 1, 0, 32'h2222_0000, 1'b0};
        // Fetch vs EXU: EXU by priority, fetch by round-robin (search starts at 0)
`ifdef CIRNO_LSARB_RR_EN
        vecs[8] = '{3'b011, {32'h0, 32'h0000_0054, 32'h0000_0050}, {32'h0, 32'hB, 32'hA},
                    {4'h0, 4'h1, 4'h2}, 32'h3333_0000, 0, 32'h0, 3'b001, 2, 1, 0, 32'h3333_0000, 1'b0};
        e5 = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        vecs[8] = '{3'b011, {32'h0, 32'h0000_0054, 32'h0000_0050}, {32'h0, 32'hB, 32'hA},
                    {4'h0, 4'h1, 4'h2}, 32'h3333_0000, 0, 32'h0, 3'b010, 2, 1, 0, 32'h3333_0000, 1'b0};
        e5 = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif

        rst = 1'b1;
        bus.i_req_val = 3'b000;
        bus.i_req_adr = '0;
        bus.i_req_wdat = '0;
        bus.i_req_wen = '0;
        bus.i_sram_rdat = 32'h0;
        bus.i_hs_iob4ls_rdy = 1'b0;
        bus.i_iob_rdat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(bus.o_req_rdy), 32'h0);
        chk("rst_err", 32'(bus.o_err), 32'h0);
        chk("rst_sram_val", 32'(bus.o_hs_ls4sram_val), 32'h0);
        chk("rst_iob_val", 32'(bus.o_hs_ls4iob_val), 32'h0);
        chk("rst_wen", 32'({bus.o_sram_wen, bus.o_iob_wen}), 32'h0);
        chk("rst_adr", bus.o_adr, 32'h0);
        chk("rst_wdat", bus.o_wdat, 32'h0);
        chk("rst_rdat", bus.o_rdat, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            @(negedge clk);
            bus.i_req_adr = v.adr;
            bus.i_req_wdat = v.wdat;
            bus.i_req_wen = v.wen;
            bus.i_sram_rdat = v.sram_rdat;
            bus.i_req_val = v.val;
            run_one(v.rdy_after, v.iob_rdat, 1'b0);
            g = oh2i(v.exp_rdy);
            chk($sformatf("v%0d_rdy", i), 32'(g_rdy), 32'(v.exp_rdy));
            chk($sformatf("v%0d_lat", i), 32'(g_lat), 32'(v.exp_lat));
            chk($sformatf("v%0d_nsram", i), 32'(g_nsram), 32'(v.exp_nsram));
            chk($sformatf("v%0d_niob", i), 32'(g_niob), 32'(v.exp_niob));
            chk($sformatf("v%0d_rdat", i), g_rdat, v.exp_rdat);
            chk($sformatf("v%0d_err", i), 32'(g_err), 32'(v.exp_err));
            chk($sformatf("v%0d_wen", i), 32'(g_wen), 32'(v.wen[g]));
            chk($sformatf("v%0d_adr", i), bus.o_adr, v.adr[g]);
            chk($sformatf("v%0d_wdat", i), bus.o_wdat, v.wdat[g]);
        end

        // T5: reset the pointer, then all three requesters held valid back to back
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_req_adr = {32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
        bus.i_req_wen = '0;
        bus.i_sram_rdat = 32'h0000_5A5A;
        bus.i_req_val = 3'b111;
        for (int i = 0; i < 4; i++) begin
            run_one(0, 32'h0, 1'b1);
            chk($sformatf("t5_gnt%0d", i), 32'(g_rdy), 32'(e5[i]));
            chk($sformatf("t5_lat%0d", i), 32'(g_lat), 32'd2);
        end
        bus.i_req_val = 3'b000;

        // T6: reset during an IOB wait drops the access; the held request is then served
        @(negedge clk);
        bus.i_req_adr = {32'h1000_0000, 32'h0, 32'h0};
        bus.i_req_val = 3'b100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t6_iob_val%0d", i), 32'(bus.o_hs_ls4iob_val), 32'h1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t6_rst_iob_val%0d", i), 32'(bus.o_hs_ls4iob_val), 32'h0);
            chk($sformatf("t6_rst_rdy%0d", i), 32'(bus.o_req_rdy), 32'h0);
        end
        chk("t6_rst_adr", bus.o_adr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_one(2, 32'h0000_6006, 1'b0);
        chk("t6_rdy", 32'(g_rdy), 32'(3'b100));
        chk("t6_lat", 32'(g_lat), 32'd3);
        chk("t6_rdat", g_rdat, 32'h0000_6006);
        chk("t6_err", 32'(g_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
